// File: rtl/minlogic_seq_ctrl.sv
// minlogic_seq_ctrl
// Registered sequencer for the three-state S/T/U minimal-logic machine.
// Incoming (a,b) symbols are buffered in a small FIFO and applied one per
// step, either free-running (run=1) or one per step pulse (run=0).
// The illegal encoding 11 is held for TRAP_CYCLES cycles and then forced
// back to S0 with a one-cycle trap pulse. Per-state visit counters
// saturate and can be cleared for debug.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid, in_a, in_b       symbol offer
//   in_ready                   FIFO has room (current level only)
//   run, step                  free-run / single-step pop control
//   load_en, load_state        direct state load (highest priority)
//   clr_cnt                    synchronous clear of visit counters
//   state_q, s, t, u           state register and its Moore decode
//   trap                       one-cycle pulse after forced recovery
//   busy                       FIFO non-empty or state is 11
//   fifo_level                 FIFO occupancy
//   cnt_s0, cnt_s1, cnt_s2     saturating entry counters
//
// state  | meaning
// ST_S0  | S: idle state, (a=1,b=0) leads to the illegal code
// ST_S1  | T: b=1 holds, b=0 advances to U
// ST_S2  | U: always returns to S
// ST_ILL | illegal 11: pops frozen, timer runs until forced recovery
module minlogic_seq_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8,
  parameter int TRAP_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic                              in_a,
  input  logic                              in_b,
  output logic                              in_ready,
  input  logic                              run,
  input  logic                              step,
  input  logic                              load_en,
  input  logic [1:0]                        load_state,
  input  logic                              clr_cnt,
  output logic [1:0]                        state_q,
  output logic                              s,
  output logic                              t,
  output logic                              u,
  output logic                              trap,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [CNT_W-1:0]                  cnt_s0,
  output logic [CNT_W-1:0]                  cnt_s1,
  output logic [CNT_W-1:0]                  cnt_s2
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TRAP_CYCLES + 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TRAP_LAST  = TW'(TRAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_S0  = 2'b00,
    ST_S1  = 2'b01,
    ST_S2  = 2'b10,
    ST_ILL = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_dest;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_nxt;
  logic             w_recover;
  logic             r_trap;

  logic [1:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [1:0]       w_sym;
  logic             w_push;
  logic             w_pop;

  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       w_inc;

  // FIFO: level is registered, so a symbol becomes poppable the cycle after
  // its push and in_ready never bypasses a same-cycle pop.
  assign in_ready = (r_level < DEPTH_L);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_level != '0) & (r_state != ST_ILL) & ~load_en & (run | step);
  assign w_sym    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_S0;
      r_timer <= '0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_trap  <= w_recover;
    end
  end

  // Next state: load beats trap recovery, which beats a pop.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_recover   = 1'b0;
    case (r_state)
      ST_S0:   w_dest = (w_sym[1] & ~w_sym[0]) ? ST_ILL : ST_S0;
      ST_S1:   w_dest = w_sym[0] ? ST_S1 : ST_S2;
      default: w_dest = ST_S0;
    endcase
    if (load_en) begin
      w_state_nxt = state_t'(load_state);
      w_timer_nxt = '0;
    end else if (r_state == ST_ILL) begin
      if (r_timer == TRAP_LAST) begin
        w_state_nxt = ST_S0;
        w_timer_nxt = '0;
        w_recover   = 1'b1;
      end else begin
        w_timer_nxt = r_timer + 1'b1;
      end
    end else if (w_pop) begin
      w_state_nxt = w_dest;
    end
  end

  // Counter increment select; pop and recovery are mutually exclusive.
  always_comb begin
    w_inc = 3'b000;
    if (w_pop) begin
      case (w_dest)
        ST_S0:   w_inc = 3'b001;
        ST_S1:   w_inc = 3'b010;
        ST_S2:   w_inc = 3'b100;
        default: w_inc = 3'b000;
      endcase
    end
    if (w_recover) w_inc = 3'b001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign state_q    = r_state;
  assign s          = (r_state == ST_S0);
  assign t          = (r_state == ST_S1);
  assign u          = (r_state == ST_S2);
  assign trap       = r_trap;
  assign busy       = (r_level != '0) | (r_state == ST_ILL);
  assign fifo_level = r_level;
  assign cnt_s0     = r_cnt[0];
  assign cnt_s1     = r_cnt[1];
  assign cnt_s2     = r_cnt[2];

endmodule

// File: doc/minlogic_seq_ctrl.md
Name: minlogic_seq_ctrl

Overview:
Registered sequencer around the three-state S/T/U minimal-logic machine. Holds the state register and buffers incoming (a,b) input symbols in a small FIFO. Applies one symbol per step, in free-run or single-step mode. Traps and recovers the illegal encoding, and keeps per-state visit counters for debug.

Parameters:
FIFO_DEPTH, 4, symbol FIFO entries (power of 2, >=2)
CNT_W, 8, width of each visit counter
TRAP_CYCLES, 2, cycles state 3 is held before forced recovery (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  symbol offered
in_a  in  1  symbol bit a
in_b  in  1  symbol bit b
in_ready  out  1  FIFO can accept a symbol
run  in  1  1 = free-run, 0 = single-step
step  in  1  one-cycle pulse that permits one pop when run=0
load_en  in  1  force state_q to load_state
load_state  in  2  state value to load
clr_cnt  in  1  synchronous clear of visit counters
state_q  out  2  current state (S0=00, S1=01, S2=10, 11 illegal)
s  out  1  state_q==00
t  out  1  state_q==01
u  out  1  state_q==10
trap  out  1  one-cycle pulse on forced recovery
busy  out  1  FIFO non-empty or state_q==11
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
cnt_s0, cnt_s1, cnt_s2  out  CNT_W  transition-entry counters

Behaviour:
- Reset (async, rst_n=0): state_q=00, FIFO flushed, fifo_level=0, in_ready=1, counters=0, trap=0, trap timer=0. Therefore s=1, t=0, u=0, busy=0. Reset mid-operation discards all buffered symbols.
- FIFO:
  - in_ready = (fifo_level < FIFO_DEPTH), based on the current level only; no same-cycle bypass.
  - Push on in_valid & in_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - A symbol pushed in cycle N can be popped no earlier than cycle N+1.
- Pop condition: FIFO non-empty & state_q!=11 & ~load_en & (run | step).
  - A step pulse with an empty FIFO is dropped, not remembered.
  - step is ignored when run=1.
- Transition on pop, registered at the same edge as the pop:
  - S0: (a=1,b=0) -> 11; otherwise stays S0.
  - S1: b=1 -> S1; b=0 -> S2.
  - S2: any -> S0.
- s/t/u are a pure decode of state_q (Moore). All three are 0 in state 11.
- Trap:
  - While state_q==11, no pops occur and the trap timer counts cycles.
  - On the edge ending the TRAP_CYCLES-th cycle in 11, state_q <= 00, the timer clears, and trap=1 for exactly the following cycle.
  - Any other exit from 11 clears the timer.
- Load:
  - load_en=1 sets state_q <= load_state at the next edge.
  - Load has priority over pop and over trap recovery, and blocks any pop that cycle.
  - Loading 11 starts a trap sequence.
  - Loads do not increment counters.
- Counters:
  - Each popped transition increments the counter of the destination state (00/01/10), including self-loops. Transitions into 11 count nothing.
  - Forced recovery increments cnt_s0.
  - Counters saturate at all-ones.
  - clr_cnt zeroes all counters and takes priority over a same-cycle increment.
- busy is combinational from fifo_level and state_q.

Test Plan:
1. Reset: assert rst_n=0 mid-run with fifo_level=3 -> immediately state_q=00, s=1, fifo_level=0, counters=0; in_ready=1 after release.
2. Sequencing: load_en with load_state=01, then run=1, push (a,b)=(0,1),(0,0),(1,1) -> state_q 01,10,00 on successive pops; t,u,s asserted in turn; cnt_s1=1, cnt_s2=1, cnt_s0=1.
3. Trap: state S0, run=1, push (1,0) then (0,0) -> state_q=11 for 2 cycles with s=t=u=0 and second symbol held (fifo_level=1); then state_q=00, trap pulses 1 cycle, cnt_s0=1; (0,0) popped the next cycle.
4. Backpressure and stepping: run=0, push 5 symbols back-to-back -> in_ready=0 after 4th, fifo_level=4, 5th held; one step pulse -> fifo_level=3, in_ready=1 next cycle, 5th accepted.
5. Saturation and priority: CNT_W=2, load S1, push five (0,1) -> cnt_s1=3; clr_cnt coincident with another pop -> cnt_s1=0.
6. Load vs pop: run=1, FIFO non-empty, load_en=1 with load_state=10 -> state_q=10, fifo_level unchanged, no counter change that cycle.
